ifmap_row_loader: RTL



---
 rtl/pe_pkg.sv | 17 +
 rtl/skid_fifo2.sv | 41 ++++
 rtl/ifmap_row_loader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the processing-element datapath: row tags seen by
// Processing_element and the IFMap row loader state encoding.
package pe_pkg;

  localparam logic [1:0] TAG_MID    = 2'b00;
  localparam logic [1:0] TAG_LAST   = 2'b01;
  localparam logic [1:0] TAG_FIRST  = 2'b10;
  localparam logic [1:0] TAG_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } loader_state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry synchronous FIFO used to absorb the scratchpad read latency
// while the IFMap buffer back-pressures. Push and pop may happen together.
module skid_fifo2 #(
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  // NOTE: the storage is reset as well so the head (and so buf_din) reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifmap_row_loader.sv
// Streams one IFMap row from the activation scratchpad into the IFMap buffer,
// tagging each word with its position in the row.
module ifmap_row_loader
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  row_len,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  buf_wen,
  output logic [DATA_WIDTH+1:0] buf_din,
  input  logic                  buf_ready
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  loader_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued_q;
  logic [LEN_WIDTH-1:0]  ret_idx_q;
  logic [LEN_WIDTH-1:0]  wr_cnt_q;
  logic                  inflight_q;

  logic [LEN_WIDTH-1:0]  len_last;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH+1:0] fifo_head;
  logic [1:0]            push_tag;
  logic                  pop;
  logic                  issue_ok;
  logic                  accept;

  assign len_last = len_q - LEN_ONE;
  assign accept   = (state_q == ST_IDLE) && start;
  assign pop      = (fifo_count != 2'd0) && buf_ready;

  // Space check: words already held plus the one in flight, less this
  // cycle's pop, must leave room for the word about to be requested.
  assign issue_ok = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    mem_ren = 1'b0;
    busy    = (state_q != ST_IDLE);
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (row_len == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_ren = (issued_q < len_q) && issue_ok;
        if (mem_ren && (issued_q == len_last)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && (wr_cnt_q == len_last)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      ret_idx_q  <= '0;
      wr_cnt_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= mem_ren;
      if (accept) begin
        addr_q    <= base_addr;
        len_q     <= row_len;
        issued_q  <= '0;
        ret_idx_q <= '0;
        wr_cnt_q  <= '0;
      end else begin
        if (mem_ren) begin
          addr_q   <= addr_q + ADDR_WIDTH'(1);
          issued_q <= issued_q + LEN_ONE;
        end
        if (inflight_q) begin
          ret_idx_q <= ret_idx_q + LEN_ONE;
        end
        if (pop) begin
          wr_cnt_q <= wr_cnt_q + LEN_ONE;
        end
      end
    end
  end

  // Tag follows the index of the word coming back from the scratchpad.
  always_comb begin
    push_tag = TAG_MID;
    if (len_q == LEN_ONE) begin
      push_tag = TAG_SINGLE;
    end else if (ret_idx_q == '0) begin
      push_tag = TAG_FIRST;
    end else if (ret_idx_q == len_last) begin
      push_tag = TAG_LAST;
    end
  end

  skid_fifo2 #(
    .WIDTH(DATA_WIDTH + 2)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (inflight_q),
    .din  ({push_tag, mem_rdata}),
    .pop  (pop),
    .count(fifo_count),
    .head (fifo_head)
  );

  assign mem_addr = addr_q;
  assign buf_wen  = (fifo_count != 2'd0);
  assign buf_din  = fifo_head;

endmodule
